// File: rtl/add_stim_chk.sv
// Stimulus generator and response checker for an adder under test: directed
// corner vectors, then a 32-bit LFSR stream, compared against a behavioural sum.
module add_stim_chk #(
    parameter int          WIDTH   = 16,
    parameter int          NUM_VEC = 256,
    parameter logic [31:0] SEED    = 32'hACE1_2468,
    parameter int          DUT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] x2,
    output logic             cin,
    input  logic [WIDTH-1:0] s,
    input  logic             cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      vec_cnt,
    output logic [15:0]      err_cnt,
    output logic [15:0]      first_err_idx,
    output logic [WIDTH:0]   first_err_exp,
    output logic [WIDTH:0]   first_err_got
);

    localparam logic [31:0]      SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [15:0]      LAST_IDX = 16'(NUM_VEC - 1);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                      state_q, state_d;
    logic [31:0]                 lfsr_q, lfsr_d;
    logic [15:0]                 next_idx_q, next_idx_d;
    logic [WIDTH-1:0]            x1_q, x1_d, x2_q, x2_d;
    logic                        cin_q, cin_d;
    logic [DUT_LAT:0][WIDTH:0]   exp_q, exp_d;
    logic [DUT_LAT:0]            vld_q, vld_d;
    logic [15:0]                 vec_cnt_q, vec_cnt_d;
    logic [15:0]                 err_cnt_q, err_cnt_d;
    logic [15:0]                 fe_idx_q, fe_idx_d;
    logic [WIDTH:0]              fe_exp_q, fe_exp_d;
    logic [WIDTH:0]              fe_got_q, fe_got_d;

    logic [15:0]      launch_idx;
    logic [31:0]      lfsr_adv;
    logic [WIDTH-1:0] vec_x1, vec_x2;
    logic             vec_cin, vec_is_lfsr, launch;
    logic [WIDTH:0]   exp_calc, got;
    logic             compare, mismatch;

    assign launch_idx = (state_q == RUN) ? next_idx_q : 16'd0;

    // Operand source for the vector about to be launched.
    always_comb begin
        lfsr_adv    = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        vec_x1      = '0;
        vec_x2      = '0;
        vec_cin     = 1'b0;
        vec_is_lfsr = 1'b0;
        case (launch_idx)
            16'd0: ;
            16'd1: begin
                vec_x1 = MSB_ONLY >> (WIDTH - 1);
                vec_x2 = '1;
            end
            16'd2: begin
                vec_x1  = '1;
                vec_x2  = '1;
                vec_cin = 1'b1;
            end
            16'd3: begin
                vec_x1 = MSB_ONLY;
                vec_x2 = MSB_ONLY;
            end
            default: begin
                vec_is_lfsr = 1'b1;
                vec_x1      = lfsr_adv[WIDTH-1:0];
                vec_x2      = lfsr_adv[31 -: WIDTH];
                vec_cin     = lfsr_adv[WIDTH/2];
            end
        endcase
        exp_calc = {1'b0, vec_x1} + {1'b0, vec_x2} + {{WIDTH{1'b0}}, vec_cin};
    end

    assign got      = {cout, s};
    assign compare  = ((state_q == RUN) || (state_q == DRAIN)) && vld_q[DUT_LAT];
    assign mismatch = (got != exp_q[DUT_LAT]);

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        next_idx_d = next_idx_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        cin_d      = cin_q;
        vec_cnt_d  = vec_cnt_q;
        err_cnt_d  = err_cnt_q;
        fe_idx_d   = fe_idx_q;
        fe_exp_d   = fe_exp_q;
        fe_got_d   = fe_got_q;
        launch     = 1'b0;
        exp_d      = exp_q;
        vld_d      = '0;
        for (int i = 1; i <= DUT_LAT; i++) begin
            exp_d[i] = exp_q[i-1];
            vld_d[i] = vld_q[i-1];
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    lfsr_d     = SEED_EFF;
                    next_idx_d = 16'd1;
                    vec_cnt_d  = '0;
                    err_cnt_d  = '0;
                    fe_idx_d   = '0;
                    fe_exp_d   = '0;
                    fe_got_d   = '0;
                    vld_d      = '0;
                    launch     = 1'b1;
                end
            end
            RUN: begin
                // With a combinational adder RUN lingers one extra edge for the final compare.
                if (next_idx_q <= LAST_IDX) begin
                    launch     = 1'b1;
                    next_idx_d = next_idx_q + 16'd1;
                    if (vec_is_lfsr) begin
                        lfsr_d = lfsr_adv;
                    end
                    if ((next_idx_q == LAST_IDX) && (DUT_LAT > 0)) begin
                        state_d = DRAIN;
                    end
                end
            end
            default: ;
        endcase

        if (compare) begin
            vec_cnt_d = vec_cnt_q + 16'd1;
            if (mismatch) begin
                err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                if (err_cnt_q == 16'd0) begin
                    fe_idx_d = vec_cnt_q;
                    fe_exp_d = exp_q[DUT_LAT];
                    fe_got_d = got;
                end
            end
            if (vec_cnt_q == LAST_IDX) begin
                state_d = DONE;
            end
        end

        if (launch) begin
            x1_d     = vec_x1;
            x2_d     = vec_x2;
            cin_d    = vec_cin;
            exp_d[0] = exp_calc;
            vld_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED_EFF;
            next_idx_q <= '0;
            x1_q       <= '0;
            x2_q       <= '0;
            cin_q      <= 1'b0;
            exp_q      <= '0;
            vld_q      <= '0;
            vec_cnt_q  <= '0;
            err_cnt_q  <= '0;
            fe_idx_q   <= '0;
            fe_exp_q   <= '0;
            fe_got_q   <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            next_idx_q <= next_idx_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            cin_q      <= cin_d;
            exp_q      <= exp_d;
            vld_q      <= vld_d;
            vec_cnt_q  <= vec_cnt_d;
            err_cnt_q  <= err_cnt_d;
            fe_idx_q   <= fe_idx_d;
            fe_exp_q   <= fe_exp_d;
            fe_got_q   <= fe_got_d;
        end
    end

    assign x1            = x1_q;
    assign x2            = x2_q;
    assign cin           = cin_q;
    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign pass          = done && (err_cnt_q == 16'd0);
    assign vec_cnt       = vec_cnt_q;
    assign err_cnt       = err_cnt_q;
    assign first_err_idx = fe_idx_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_got = fe_got_q;

endmodule

// File: tb/tb_add_stim_chk.sv
// Bench for add_stim_chk: four instances (default, DUT_LAT=2, DUT_LAT=1 mismatch,
// SEED=0) driven by bench-side adders with selectable fault injection.
module tb_add_stim_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_o;
    int   checks   = 0;
    int   failures = 0;

    // Fault control for the instance-a adder: 0 none, 1 s[5] stuck 0, 2 flip bit fb when x1[3:0]==fk
    logic [1:0] mode = 2'd0;
    logic [3:0] fk   = 4'd0;
    logic [4:0] fb   = 5'd0;

    logic [15:0] x1_a, x2_a, s_a, vc_a, ec_a, fi_a;
    logic        cin_a, cout_a, busy_a, done_a, pass_a;
    logic [16:0] fe_a, fg_a, sum_a;
    logic [15:0] x1_b, x2_b, s_b, vc_b, ec_b, fi_b;
    logic        cin_b, cout_b, busy_b, done_b, pass_b;
    logic [16:0] fe_b, fg_b;
    logic [15:0] x1_c, x2_c, s_c, vc_c, ec_c, fi_c;
    logic        cin_c, cout_c, busy_c, done_c, pass_c;
    logic [16:0] fe_c, fg_c;
    logic [15:0] x1_d, x2_d, s_d, vc_d, ec_d, fi_d;
    logic        cin_d, cout_d, busy_d, done_d, pass_d;
    logic [16:0] fe_d, fg_d;
    logic [16:0] r1_b = '0, r2_b = '0, r1_c = '0, r2_c = '0;

    add_stim_chk u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .x1(x1_a), .x2(x2_a), .cin(cin_a),
        .s(s_a), .cout(cout_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .vec_cnt(vc_a), .err_cnt(ec_a), .first_err_idx(fi_a),
        .first_err_exp(fe_a), .first_err_got(fg_a));

    add_stim_chk #(.NUM_VEC(32), .DUT_LAT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_o), .x1(x1_b), .x2(x2_b), .cin(cin_b),
        .s(s_b), .cout(cout_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .vec_cnt(vc_b), .err_cnt(ec_b), .first_err_idx(fi_b),
        .first_err_exp(fe_b), .first_err_got(fg_b));

    add_stim_chk #(.NUM_VEC(32), .DUT_LAT(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start_o), .x1(x1_c), .x2(x2_c), .cin(cin_c),
        .s(s_c), .cout(cout_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .vec_cnt(vc_c), .err_cnt(ec_c), .first_err_idx(fi_c),
        .first_err_exp(fe_c), .first_err_got(fg_c));

    add_stim_chk #(.NUM_VEC(8), .SEED(32'h0)) u_d (
        .clk(clk), .rst_n(rst_n), .start(start_o), .x1(x1_d), .x2(x2_d), .cin(cin_d),
        .s(s_d), .cout(cout_d), .busy(busy_d), .done(done_d), .pass(pass_d),
        .vec_cnt(vc_d), .err_cnt(ec_d), .first_err_idx(fi_d),
        .first_err_exp(fe_d), .first_err_got(fg_d));

    // Adders under test
    always_comb begin
        sum_a = {1'b0, x1_a} + {1'b0, x2_a} + {16'd0, cin_a};
        if (mode == 2'd1) sum_a[5] = 1'b0;
        else if (mode == 2'd2 && x1_a[3:0] == fk) sum_a[fb] = ~sum_a[fb];
    end
    assign {cout_a, s_a} = sum_a;
    assign {cout_d, s_d} = {1'b0, x1_d} + {1'b0, x2_d} + {16'd0, cin_d};

    always @(posedge clk) begin
        r1_b <= {1'b0, x1_b} + {1'b0, x2_b} + {16'd0, cin_b};
        r2_b <= r1_b;
        r1_c <= {1'b0, x1_c} + {1'b0, x2_c} + {16'd0, cin_c};
        r2_c <= r1_c;
    end
    assign {cout_b, s_b} = r2_b;
    assign {cout_c, s_c} = r2_c;

    typedef struct {
        logic [15:0] x1;
        logic [15:0] x2;
        logic        cin;
        logic [16:0] sum;
    } dir_t;
    dir_t dir_tab[4];

    // Vectors packed as {x1, x2, cin}
    logic [32:0] refa [256];
    logic [32:0] refd [8];
    logic [32:0] seen [256];

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [16:0] vsum(input logic [32:0] v);
        return {1'b0, v[32:17]} + {1'b0, v[16:1]} + {16'd0, v[0]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Operand stream monitor for instance a
    int mon_idx  = 0;
    int cur_len  = 0;
    int last_len = 0;
    always @(negedge clk) begin
        if (!busy_a) begin
            mon_idx <= 0;
            if (cur_len != 0) begin
                last_len <= cur_len;
                cur_len  <= 0;
            end
        end else begin
            cur_len <= cur_len + 1;
            if (mon_idx < 256) begin
                seen[mon_idx] <= {x1_a, x2_a, cin_a};
                if (mon_idx >= 4) chk($sformatf("lfsr_vec[%0d]", mon_idx), {x1_a, x2_a, cin_a}, refa[mon_idx]);
            end
            mon_idx <= mon_idx + 1;
        end
    end

    task automatic run_a(input int pulse_at);
        int cyc;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        chk("start_clears_vec_cnt", vc_a, 0);
        chk("start_clears_err_cnt", ec_a, 0);
        chk("start_clears_first_idx", fi_a, 0);
        chk("busy_after_start", busy_a, 1);
        cyc = 0;
        while (!done_a && cyc < 700) begin
            start_a = (cyc == pulse_at);
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        chk("run_done", done_a, 1);
        @(negedge clk);
        chk("busy_len", last_len, 256);
    endtask

    task automatic check_a();
        int cnt, first;
        logic [16:0] e, g, sm, gt;
        logic [15:0] vx1;
        cnt = 0; first = -1; e = '0; g = '0;
        for (int i = 0; i < 256; i++) begin
            sm  = (i < 4) ? dir_tab[i].sum : vsum(refa[i]);
            vx1 = refa[i][32:17];
            gt  = sm;
            if (mode == 2'd1) gt[5] = 1'b0;
            else if (mode == 2'd2 && vx1[3:0] == fk) gt[fb] = ~gt[fb];
            if (gt != sm) begin
                cnt++;
                if (first < 0) begin first = i; e = sm; g = gt; end
            end
        end
        if (first < 0) first = 0;
        $display("run mode=%0d fk=%0d fb=%0d vec_cnt=%0d err_cnt=%0d first_idx=%0d pass=%0d",
                 mode, fk, fb, vc_a, ec_a, fi_a, pass_a);
        chk("vec_cnt", vc_a, 256);
        chk("err_cnt", ec_a, cnt);
        chk("first_err_idx", fi_a, first);
        chk("first_err_exp", fe_a, e);
        chk("first_err_got", fg_a, g);
        chk("pass", pass_a, (cnt == 0));
    endtask

    initial begin
        logic [31:0] l;
        int cyc, len_b, idx_d;

        dir_tab[0] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
        dir_tab[1] = '{16'h0001, 16'hFFFF, 1'b0, 17'h10000};
        dir_tab[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
        dir_tab[3] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
        for (int i = 0; i < 4; i++) begin
            refa[i] = {dir_tab[i].x1, dir_tab[i].x2, dir_tab[i].cin};
            refd[i] = refa[i];
        end
        l = 32'hACE1_2468;
        for (int i = 4; i < 256; i++) begin
            l = lfsr_step(l);
            refa[i] = {l[15:0], l[31:16], l[8]};
        end
        l = 32'h1;
        for (int i = 4; i < 8; i++) begin
            l = lfsr_step(l);
            refd[i] = {l[15:0], l[31:16], l[8]};
        end

        rst_n = 1'b0; start_a = 1'b0; start_o = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x1", x1_a, 0);
        chk("rst_x2", x2_a, 0);
        chk("rst_cin", cin_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_counts", {vc_a, ec_a, fi_a}, 0);
        chk("rst_first_err", {fe_a, fg_a}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency variants and SEED=0 instance, started together
        @(negedge clk) start_o = 1'b1;
        @(negedge clk) start_o = 1'b0;
        cyc = 0; len_b = 0; idx_d = 0;
        while (cyc < 200 && !(done_b && done_c && done_d)) begin
            if (busy_b) len_b++;
            if (busy_d) begin
                if (idx_d >= 4 && idx_d < 8) chk($sformatf("seed0_vec[%0d]", idx_d), {x1_d, x2_d, cin_d}, refd[idx_d]);
                idx_d++;
            end
            @(negedge clk);
            cyc++;
        end
        $display("run lat2 vec_cnt=%0d err_cnt=%0d | lat1 err_cnt=%0d | seed0 vec_cnt=%0d", vc_b, ec_b, ec_c, vc_d);
        chk("lat2_done", done_b, 1);
        chk("lat2_vec_cnt", vc_b, 32);
        chk("lat2_err_cnt", ec_b, 0);
        chk("lat2_pass", pass_b, 1);
        chk("lat2_busy_len", len_b, 34);
        chk("lat1_done", done_c, 1);
        chk("lat1_vec_cnt", vc_c, 32);
        chk("lat1_err_nonzero", (ec_c != 0), 1);
        chk("lat1_pass", pass_c, 0);
        chk("seed0_done", done_d, 1);
        chk("seed0_vec_cnt", vc_d, 8);
        chk("seed0_pass", pass_d, 1);
        chk("seed0_busy_len", idx_d, 8);

        // Clean run with a start pulse mid-RUN that must be ignored
        mode = 2'd0;
        run_a(100);
        check_a();
        for (int i = 0; i < 4; i++)
            chk($sformatf("directed_vec[%0d]", i), seen[i], {dir_tab[i].x1, dir_tab[i].x2, dir_tab[i].cin});

        // Restart from DONE with s[5] stuck low
        mode = 2'd1;
        run_a(-1);
        check_a();
        chk("stuck5_first_idx", fi_a, 2);
        chk("stuck5_first_exp", fe_a, 17'h1FFFF);
        chk("stuck5_first_got", fg_a, 17'h1FFDF);

        for (int r = 0; r < 3; r++) begin
            mode = 2'd2;
            fk   = 4'($urandom_range(0, 15));
            fb   = 5'($urandom_range(0, 16));
            run_a(-1);
            check_a();
        end

        // Asynchronous reset at vector 50 of a failing run
        mode = 2'd1;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        repeat (50) @(negedge clk);
        chk("pre_rst_x1_vec50", {x1_a, x2_a, cin_a}, refa[50]);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_ops", {x1_a, x2_a, cin_a}, 0);
        chk("midrst_counts", {vc_a, ec_a, fi_a}, 0);
        chk("midrst_first_err", {fe_a, fg_a}, 0);
        chk("midrst_other_done", {done_b, done_c, done_d}, 0);
        @(negedge clk) rst_n = 1'b1;
        mode = 2'd0;
        run_a(-1);
        check_a();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
